stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Multi-cycle control unit for the four-stage core (fetch, decode, operand read, writeback/STAGE3).
- Owns the architectural state registers: pc, is_powered_on, execute_from_ram, flag_last_zero.
- Steps one instruction at a time through the stages and arbitrates the single RAM port between instruction fetch, operand read and the STAGE3 write.
- Commits the STAGE3 results (pc_next, power and RAM-execute flags) at the writeback cycle.

Parameters:
- RAM_WAIT, 1, extra wait cycles per RAM read access (0..15); RAM writes always take 1 cycle.
- RESET_PC, 0, pc value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- rom_address  out  16  instruction ROM address (= pc)
- rom_data  in  32  ROM instruction, combinational
- ram_address  out  16  shared RAM address
- ram_in  out  32  RAM write data
- ram_is_write  out  1  RAM write strobe
- ram_out  in  32  RAM read data, valid after RAM_WAIT cycles
- instruction  out  32  latched instruction register
- s2_read_req  in  1  decoder requests an operand read (sampled in DECODE)
- s2_read_address  in  16  operand address
- operand_value  out  32  latched operand
- s3_ram_address, s3_ram_in, s3_ram_is_write  in  16/32/1  STAGE3 RAM request
- s3_output_is_write  in  1  STAGE3 output-device write
- s3_pc_next  in  16  STAGE3 next pc
- s3_execute_from_ram_new, s3_is_powered_on_new  in  1/1  STAGE3 flag updates
- flag_zero_new, flag_update  in  1/1  ALU zero flag and its enable
- output_is_write  out  1  gated output-device strobe
- pc  out  16  current pc
- is_powered_on, execute_from_ram, flag_last_zero  out  1 each  architectural flags
- stage  out  3  current state encoding, for debug and the bench

Behaviour:
- Reset values: pc=RESET_PC, is_powered_on=1, execute_from_ram=0, flag_last_zero=0, instruction=0, operand_value=0, state=FETCH, wait counter=0. All strobes are 0.
- Reset asserted in any state, including HALT or mid-wait, aborts the in-flight instruction and drops any write strobe in the same cycle.
- States: FETCH, FETCH_WAIT, DECODE, OPERAND, OPERAND_WAIT, WRITEBACK, HALT.
- FETCH:
  - execute_from_ram=0: latch rom_data into instruction, go to DECODE.
  - execute_from_ram=1: ram_address=pc, ram_is_write=0. If RAM_WAIT=0, latch ram_out and go to DECODE; else load counter=RAM_WAIT and go to FETCH_WAIT.
- FETCH_WAIT: decrement counter; when counter reaches 1, latch ram_out next edge, go to DECODE.
- DECODE: if s2_read_req, go to OPERAND; else go to WRITEBACK.
- OPERAND / OPERAND_WAIT: same timing as the RAM fetch, using s2_read_address; latch operand_value. ROM is never an operand source.
- WRITEBACK (exactly 1 cycle):
  - RAM port = s3_* request; ram_is_write = s3_ram_is_write.
  - output_is_write = s3_output_is_write.
  - At the edge: pc<=s3_pc_next, execute_from_ram<=s3_execute_from_ram_new, is_powered_on<=s3_is_powered_on_new.
  - If flag_update, flag_last_zero<=flag_zero_new.
  - Next state is HALT if s3_is_powered_on_new=0, else FETCH.
- HALT: all strobes 0, registers frozen; only reset exits.
- RAM arbitration is static by state. ram_is_write may be 1 only in WRITEBACK. Outside RAM-using states, ram_address=pc.
- Latency per instruction with RAM_WAIT=W:
  - base 3 cycles (ROM fetch, DECODE, WRITEBACK);
  - +W for a RAM fetch;
  - +1+W for an operand read.
- pc arithmetic is 16-bit; wrap 0xFFFC+4 -> 0x0000 is produced by STAGE3, and the sequencer accepts any value unchanged.
- An instruction fetched from RAM may overwrite itself in WRITEBACK; the next fetch sees the new data.

Decomposition:
- Package core_pkg: state encoding constants (FETCH=0 ... HALT=6), PC_WIDTH=16, WORD_WIDTH=32.
- One sub-module, ram_port_mux: combinational selection of address/data/write between fetch, operand and writeback, driven by the state.
- Sequencer FSM and wait counter stay in the top module.

Test Plan:
- ROM fetch, no operand, s3_pc_next=pc+4: from reset, pc goes 0->4->8 every 3 cycles; stage sequence is FETCH, DECODE, WRITEBACK.
- execute_from_ram=1, RAM_WAIT=2, ram_out=0xDEADBEEF at pc 0x0040: instruction=0xDEADBEEF at DECODE; instruction takes 5 cycles.
- s2_read_req=1, s2_read_address=15, ram_out=97: operand_value=97; ram_address=15 during OPERAND.
- Writeback with s3_ram_is_write=1, address 97, data 99: ram_is_write high for exactly 1 cycle in WRITEBACK with ram_address=97 and ram_in=99. Then s3_output_is_write=1 gives output_is_write=1 for that cycle only.
- Halt: s3_is_powered_on_new=0 gives is_powered_on=0 and stage=HALT, and pc stays frozen for 20 cycles.
- Reset in OPERAND_WAIT: the next cycle is FETCH, pc=RESET_PC, and no write strobe is seen.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the four-stage core.
// State encoding, datapath widths.
package core_pkg;

    localparam int PC_WIDTH   = 16;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        FETCH        = 3'd0,
        FETCH_WAIT   = 3'd1,
        DECODE       = 3'd2,
        OPERAND      = 3'd3,
        OPERAND_WAIT = 3'd4,
        WRITEBACK    = 3'd5,
        HALT         = 3'd6
    } state_e;

endpackage

// File: rtl/ram_port_mux.sv
// Static per-state arbitration of the single RAM port.
// Write strobes exist only in WRITEBACK and are killed by reset.
module ram_port_mux
    import core_pkg::*;
(
    input  state_e                  state_i,
    input  logic                    kill_i,
    input  logic [PC_WIDTH-1:0]     pc_i,
    input  logic [PC_WIDTH-1:0]     s2_read_address_i,
    input  logic [PC_WIDTH-1:0]     s3_ram_address_i,
    input  logic [WORD_WIDTH-1:0]   s3_ram_in_i,
    input  logic                    s3_ram_is_write_i,
    input  logic                    s3_output_is_write_i,
    output logic [PC_WIDTH-1:0]     ram_address_o,
    output logic [WORD_WIDTH-1:0]   ram_in_o,
    output logic                    ram_is_write_o,
    output logic                    output_is_write_o
);

    always_comb begin
        ram_address_o     = pc_i;
        ram_in_o          = '0;
        ram_is_write_o    = 1'b0;
        output_is_write_o = 1'b0;
        case (state_i)
            OPERAND, OPERAND_WAIT: begin
                ram_address_o = s2_read_address_i;
            end
            WRITEBACK: begin
                ram_address_o     = s3_ram_address_i;
                ram_in_o          = s3_ram_in_i;
                ram_is_write_o    = s3_ram_is_write_i & ~kill_i;
                output_is_write_o = s3_output_is_write_i & ~kill_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle sequencer: steps one instruction through fetch,
// decode, operand read and writeback; owns pc and core flags.
module stage_sequencer
    import core_pkg::*;
#(
    parameter int                  RAM_WAIT = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [PC_WIDTH-1:0]   rom_address,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic [PC_WIDTH-1:0]   ram_address,
    output logic [WORD_WIDTH-1:0] ram_in,
    output logic                  ram_is_write,
    input  logic [WORD_WIDTH-1:0] ram_out,
    output logic [WORD_WIDTH-1:0] instruction,
    input  logic                  s2_read_req,
    input  logic [PC_WIDTH-1:0]   s2_read_address,
    output logic [WORD_WIDTH-1:0] operand_value,
    input  logic [PC_WIDTH-1:0]   s3_ram_address,
    input  logic [WORD_WIDTH-1:0] s3_ram_in,
    input  logic                  s3_ram_is_write,
    input  logic                  s3_output_is_write,
    input  logic [PC_WIDTH-1:0]   s3_pc_next,
    input  logic                  s3_execute_from_ram_new,
    input  logic                  s3_is_powered_on_new,
    input  logic                  flag_zero_new,
    input  logic                  flag_update,
    output logic                  output_is_write,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  is_powered_on,
    output logic                  execute_from_ram,
    output logic                  flag_last_zero,
    output logic [2:0]            stage
);

    localparam logic [3:0] WAIT_CNT = 4'(RAM_WAIT);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic                    pwr_q, pwr_d;
    logic                    efr_q, efr_d;
    logic                    flz_q, flz_d;
    logic [WORD_WIDTH-1:0]   instr_q, instr_d;
    logic [WORD_WIDTH-1:0]   opnd_q, opnd_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            pwr_q   <= 1'b1;
            efr_q   <= 1'b0;
            flz_q   <= 1'b0;
            instr_q <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            pwr_q   <= pwr_d;
            efr_q   <= efr_d;
            flz_q   <= flz_d;
            instr_q <= instr_d;
            opnd_q  <= opnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        pwr_d   = pwr_q;
        efr_d   = efr_q;
        flz_d   = flz_q;
        instr_d = instr_q;
        opnd_d  = opnd_q;
        case (state_q)
            FETCH: begin
                if (!efr_q) begin
                    instr_d = rom_data;
                    state_d = DECODE;
                end else if (RAM_WAIT == 0) begin
                    instr_d = ram_out;
                    state_d = DECODE;
                end else begin
                    cnt_d   = WAIT_CNT;
                    state_d = FETCH_WAIT;
                end
            end
            // Data is sampled on the edge that ends the last wait cycle.
            FETCH_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    instr_d = ram_out;
                    state_d = DECODE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DECODE: begin
                state_d = s2_read_req ? OPERAND : WRITEBACK;
            end
            OPERAND: begin
                if (RAM_WAIT == 0) begin
                    opnd_d  = ram_out;
                    state_d = WRITEBACK;
                end else begin
                    cnt_d   = WAIT_CNT;
                    state_d = OPERAND_WAIT;
                end
            end
            OPERAND_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    opnd_d  = ram_out;
                    state_d = WRITEBACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITEBACK: begin
                pc_d  = s3_pc_next;
                efr_d = s3_execute_from_ram_new;
                pwr_d = s3_is_powered_on_new;
                if (flag_update) begin
                    flz_d = flag_zero_new;
                end
                state_d = s3_is_powered_on_new ? FETCH : HALT;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    ram_port_mux u_mux (
        .state_i              (state_q),
        .kill_i               (reset),
        .pc_i                 (pc_q),
        .s2_read_address_i    (s2_read_address),
        .s3_ram_address_i     (s3_ram_address),
        .s3_ram_in_i          (s3_ram_in),
        .s3_ram_is_write_i    (s3_ram_is_write),
        .s3_output_is_write_i (s3_output_is_write),
        .ram_address_o        (ram_address),
        .ram_in_o             (ram_in),
        .ram_is_write_o       (ram_is_write),
        .output_is_write_o    (output_is_write)
    );

    assign rom_address      = pc_q;
    assign instruction      = instr_q;
    assign operand_value    = opnd_q;
    assign pc               = pc_q;
    assign is_powered_on    = pwr_q;
    assign execute_from_ram = efr_q;
    assign flag_last_zero   = flz_q;
    assign stage            = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus random
// instructions checked against an instruction-level model.
module tb_stage_sequencer;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic [15:0] ram_address;
    logic [31:0] ram_in;
    logic        ram_is_write;
    logic [31:0] ram_out;
    logic [31:0] instruction;
    logic        s2_read_req = 1'b0;
    logic [15:0] s2_read_address = '0;
    logic [31:0] operand_value;
    logic [15:0] s3_ram_address = '0;
    logic [31:0] s3_ram_in = '0;
    logic        s3_ram_is_write = 1'b0;
    logic        s3_output_is_write = 1'b0;
    logic [15:0] s3_pc_next = '0;
    logic        s3_execute_from_ram_new = 1'b0;
    logic        s3_is_powered_on_new = 1'b1;
    logic        flag_zero_new = 1'b0;
    logic        flag_update = 1'b0;
    logic        output_is_write;
    logic [15:0] pc;
    logic        is_powered_on;
    logic        execute_from_ram;
    logic        flag_last_zero;
    logic [2:0]  stage;

    int checks = 0;
    int errors = 0;

    // Environment RAM (written by the DUT) and the model's own copy.
    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];

    logic [15:0] m_pc;
    logic        m_pwr, m_efr, m_flz;
    logic [31:0] m_instr, m_opnd;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {~a, a} ^ 32'h1234_5678;
    endfunction

    assign rom_data = rom_word(rom_address);
    assign ram_out  = mem[ram_address[7:0]];

    always @(posedge clk)
        if (ram_is_write === 1'b1)
            mem[ram_address[7:0]] <= ram_in;

    stage_sequencer #(.RAM_WAIT(W), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .rom_address(rom_address), .rom_data(rom_data),
        .ram_address(ram_address), .ram_in(ram_in),
        .ram_is_write(ram_is_write), .ram_out(ram_out),
        .instruction(instruction),
        .s2_read_req(s2_read_req), .s2_read_address(s2_read_address),
        .operand_value(operand_value),
        .s3_ram_address(s3_ram_address), .s3_ram_in(s3_ram_in),
        .s3_ram_is_write(s3_ram_is_write),
        .s3_output_is_write(s3_output_is_write),
        .s3_pc_next(s3_pc_next),
        .s3_execute_from_ram_new(s3_execute_from_ram_new),
        .s3_is_powered_on_new(s3_is_powered_on_new),
        .flag_zero_new(flag_zero_new), .flag_update(flag_update),
        .output_is_write(output_is_write),
        .pc(pc), .is_powered_on(is_powered_on),
        .execute_from_ram(execute_from_ram),
        .flag_last_zero(flag_last_zero), .stage(stage)
    );

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        mem[a]   = d;
        m_mem[a] = d;
    endtask

    task automatic idle_inputs();
        s2_read_req        = 1'b0;
        s3_ram_is_write    = 1'b0;
        s3_output_is_write = 1'b0;
        flag_update        = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_is_write !== 1'b0 || output_is_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b/%b want 0/0",
                     ram_is_write, output_is_write);
        end
        reset = 1'b0;
        m_pc = 16'h0000; m_pwr = 1'b1; m_efr = 1'b0; m_flz = 1'b0;
        m_instr = '0; m_opnd = '0;
        checks++;
        if (stage !== 3'd0 || pc !== 16'h0 || is_powered_on !== 1'b1 ||
            execute_from_ram !== 1'b0 || flag_last_zero !== 1'b0 ||
            instruction !== 32'h0 || operand_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: stage=%0d pc=%h pwr=%b efr=%b flz=%b ins=%h op=%h",
                     stage, pc, is_powered_on, execute_from_ram,
                     flag_last_zero, instruction, operand_value);
        end
    endtask

    // One instruction from a FETCH-state negedge to the next.
    task automatic run_instr(
        input logic rd, input logic [15:0] raddr,
        input logic we, input logic [15:0] waddr, input logic [31:0] wdata,
        input logic owe, input logic [15:0] pcn,
        input logic efrn, input logic pwrn,
        input logic fu, input logic fz);
        logic [2:0]  seq [$];
        logic [31:0] exp_instr, exp_opnd;
        int nw, no;
        nw = 0;
        no = 0;
        exp_instr = m_efr ? m_mem[m_pc[7:0]] : rom_word(m_pc);
        exp_opnd  = rd ? m_mem[raddr[7:0]] : m_opnd;
        seq.push_back(3'd0);
        if (m_efr) repeat (W) seq.push_back(3'd1);
        seq.push_back(3'd2);
        if (rd) begin
            seq.push_back(3'd3);
            repeat (W) seq.push_back(3'd4);
        end
        seq.push_back(3'd5);
        s2_read_req = rd; s2_read_address = raddr;
        s3_ram_is_write = we; s3_ram_address = waddr; s3_ram_in = wdata;
        s3_output_is_write = owe; s3_pc_next = pcn;
        s3_execute_from_ram_new = efrn; s3_is_powered_on_new = pwrn;
        flag_update = fu; flag_zero_new = fz;
        foreach (seq[i]) begin
            checks++;
            if (stage !== seq[i]) begin
                errors++;
                $display("FAIL seq[%0d]: stage=%0d want %0d", i, stage, seq[i]);
            end
            if (seq[i] == 3'd2) begin
                checks++;
                if (instruction !== exp_instr) begin
                    errors++;
                    $display("FAIL decode_instr: got %h want %h",
                             instruction, exp_instr);
                end
            end
            if (seq[i] == 3'd3) begin
                checks++;
                if (ram_address !== raddr) begin
                    errors++;
                    $display("FAIL operand_addr: got %h want %h",
                             ram_address, raddr);
                end
            end
            if (ram_is_write === 1'b1) begin
                nw++;
                checks++;
                if (seq[i] != 3'd5 || ram_address !== waddr ||
                    ram_in !== wdata) begin
                    errors++;
                    $display("FAIL wr_port: st=%0d addr=%h data=%h want 5/%h/%h",
                             seq[i], ram_address, ram_in, waddr, wdata);
                end
            end
            if (output_is_write === 1'b1) begin
                no++;
                checks++;
                if (seq[i] != 3'd5) begin
                    errors++;
                    $display("FAIL out_wr_state: st=%0d want 5", seq[i]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        m_pc = pcn; m_efr = efrn; m_pwr = pwrn;
        if (fu) m_flz = fz;
        m_instr = exp_instr; m_opnd = exp_opnd;
        if (we) m_mem[waddr[7:0]] = wdata;
        idle_inputs();
        checks++;
        if (stage !== (pwrn ? 3'd0 : 3'd6) || pc !== m_pc ||
            is_powered_on !== m_pwr || execute_from_ram !== m_efr ||
            flag_last_zero !== m_flz) begin
            errors++;
            $display("FAIL commit: stage=%0d pc=%h pwr=%b efr=%b flz=%b want pc=%h pwr=%b efr=%b flz=%b",
                     stage, pc, is_powered_on, execute_from_ram,
                     flag_last_zero, m_pc, m_pwr, m_efr, m_flz);
        end
        checks++;
        if (instruction !== m_instr || operand_value !== m_opnd) begin
            errors++;
            $display("FAIL latches: ins=%h op=%h want %h/%h",
                     instruction, operand_value, m_instr, m_opnd);
        end
        checks++;
        if (nw != int'(we) || no != int'(owe)) begin
            errors++;
            $display("FAIL strobe_count: wr=%0d out=%0d want %0d/%0d",
                     nw, no, we, owe);
        end
    endtask

    task automatic test_rom_fetch();
        test_reset();
        run_instr(0, 0, 0, 0, 0, 0, m_pc + 16'd4, 0, 1, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, m_pc + 16'd4, 0, 1, 1, 1);
        checks++;
        if (pc !== 16'd8) begin
            errors++;
            $display("FAIL rom_pc: got %h want 0008", pc);
        end
    endtask

    task automatic test_ram_fetch();
        poke(8'h40, 32'hDEAD_BEEF);
        run_instr(0, 0, 0, 0, 0, 0, 16'h0040, 1, 1, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 16'h0044, 0, 1, 1, 0);
        checks++;
        if (instruction !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_instr: got %h want deadbeef", instruction);
        end
    endtask

    task automatic test_operand();
        poke(8'd15, 32'd97);
        run_instr(1, 16'd15, 0, 0, 0, 0, m_pc + 16'd4, 0, 1, 0, 0);
        checks++;
        if (operand_value !== 32'd97) begin
            errors++;
            $display("FAIL operand_value: got %0d want 97", operand_value);
        end
    endtask

    task automatic test_writeback();
        run_instr(0, 0, 1, 16'd97, 32'd99, 0, m_pc + 16'd4, 0, 1, 0, 0);
        checks++;
        if (mem[97] !== 32'd99) begin
            errors++;
            $display("FAIL ram_written: got %0d want 99", mem[97]);
        end
        run_instr(0, 0, 0, 0, 0, 1, m_pc + 16'd4, 0, 1, 0, 0);
    endtask

    task automatic test_self_overwrite();
        poke(8'h80, 32'h1111_2222);
        run_instr(0, 0, 0, 0, 0, 0, 16'h0080, 1, 1, 0, 0);
        run_instr(0, 0, 1, 16'h0080, 32'hCAFE_F00D, 0, 16'h0080, 1, 1, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 16'hFFFC, 0, 1, 0, 0);
        checks++;
        if (instruction !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL self_overwrite: got %h want cafef00d", instruction);
        end
        run_instr(0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) poke(i[7:0], $urandom);
        for (int n = 0; n < 40; n++) begin
            logic [15:0] pcn;
            pcn = 16'($urandom) & 16'hFFFC;
            run_instr(1'($urandom), 16'($urandom), 1'($urandom),
                      16'($urandom), $urandom, 1'($urandom), pcn,
                      1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_halt();
        logic [15:0] frozen;
        run_instr(0, 0, 0, 0, 0, 0, 16'h0123, 0, 0, 0, 0);
        frozen = m_pc;
        s3_ram_is_write = 1'b1;
        s3_output_is_write = 1'b1;
        s3_is_powered_on_new = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (stage !== 3'd6 || pc !== frozen || is_powered_on !== 1'b0 ||
                ram_is_write !== 1'b0 || output_is_write !== 1'b0) begin
                errors++;
                $display("FAIL halt[%0d]: stage=%0d pc=%h pwr=%b wr=%b out=%b",
                         i, stage, pc, is_powered_on, ram_is_write,
                         output_is_write);
            end
        end
        idle_inputs();
        test_reset();
    endtask

    task automatic test_reset_mid_wait();
        int k;
        test_reset();
        s2_read_req = 1'b1; s2_read_address = 16'd20;
        s3_ram_is_write = 1'b1; s3_ram_address = 16'd21;
        s3_output_is_write = 1'b1; s3_pc_next = 16'h0200;
        k = 0;
        while (stage !== 3'd4 && k < 10) begin
            @(posedge clk); @(negedge clk); k++;
        end
        checks++;
        if (stage !== 3'd4) begin
            errors++;
            $display("FAIL reach_opwait: stage=%0d want 4", stage);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ram_is_write !== 1'b0 || output_is_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_opwait_strobe: %b/%b want 0/0",
                     ram_is_write, output_is_write);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        checks++;
        if (stage !== 3'd0 || pc !== 16'h0000) begin
            errors++;
            $display("FAIL rst_opwait_state: stage=%0d pc=%h want 0/0000",
                     stage, pc);
        end
        k = 0;
        while (stage !== 3'd5 && k < 10) begin
            @(posedge clk); @(negedge clk); k++;
        end
        checks++;
        if (stage !== 3'd5 || ram_is_write !== 1'b1) begin
            errors++;
            $display("FAIL reach_wb: stage=%0d wr=%b want 5/1",
                     stage, ram_is_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ram_is_write !== 1'b0 || output_is_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb_strobe: %b/%b want 0/0",
                     ram_is_write, output_is_write);
        end
        idle_inputs();
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        checks++;
        if (stage !== 3'd0 || pc !== 16'h0000 || mem[21] === 32'h0) begin
            errors++;
            $display("FAIL rst_wb_state: stage=%0d pc=%h want 0/0000", stage, pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) poke(i[7:0], 32'h0);
        mem[21] = 32'h5555_AAAA;
        m_mem[21] = 32'h5555_AAAA;
        test_reset();
        test_rom_fetch();
        test_ram_fetch();
        test_operand();
        test_writeback();
        test_self_overwrite();
        test_random();
        test_halt();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
